// File: rtl/fnd_pkg.sv
// Shared constants for the FND display stage: segment codes, count limit,
// converter state encoding and the registered display payload.
package fnd_pkg;

    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;

    localparam logic [BIN_W-1:0] MAX_COUNT = 14'd9999;

    // Segment codes {dp,g,f,e,d,c,b,a}, active low, dp always off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef struct packed {
        logic       dash;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } disp_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/fnd_controller_bin2bcd.sv
// Sequential double-dabble: one capture cycle, 14 add-3/shift cycles, one
// DONE cycle during which o_bcd holds the final result.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] i_bin,
    input  logic             i_start,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_done,
    output logic             o_busy
);

    logic [1:0]             state, state_n;
    logic [BCD_W+BIN_W-1:0] sr, sr_n;
    logic [3:0]             cnt, cnt_n;
    logic [BCD_W-1:0]       adj;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        adj     = sr[BCD_W+BIN_W-1:BIN_W];
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    sr_n    = {16'd0, i_bin};
                    cnt_n   = 4'd0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < 4; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
                sr_n  = {adj[BCD_W-2:0], sr[BIN_W-1:0], 1'b0};
                cnt_n = cnt + 4'd1;
                if (cnt == 4'd13) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sr     <= '0;
            cnt    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            cnt    <= cnt_n;
            o_busy <= (state_n != ST_IDLE);
            o_done <= (state_n == ST_DONE);
        end
    end

    assign o_bcd = sr[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/fnd_controller.sv
// Display stage: change-detect feeding the BCD converter, scan prescaler,
// digit mux with optional leading-zero blanking and registered pin drive.
module fnd_controller
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] i_count,
    output logic [3:0]       fnd_com,
    output logic [7:0]       fnd_data,
    output logic             o_busy
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [1:0]       idx;
    logic             valid;
    logic [BIN_W-1:0] last_val;
    disp_t            disp;
    logic [BCD_W-1:0] bcd;
    logic             done;
    logic             start_c;
    logic [3:0]       digit_c;
    logic             blank_c;
    logic [7:0]       seg_c;

    // Converter only accepts a new value while idle; last_val tracks it
    assign start_c = !o_busy && (!valid || (i_count != last_val));

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .i_bin  (i_count),
        .i_start(start_c),
        .o_bcd  (bcd),
        .o_done (done),
        .o_busy (o_busy)
    );

    always_comb begin
        digit_c = disp.d0;
        blank_c = 1'b0;
        case (idx)
            2'd0: digit_c = disp.d0;
            2'd1: begin
                digit_c = disp.d1;
                blank_c = (disp.d3 == 4'd0) && (disp.d2 == 4'd0) && (disp.d1 == 4'd0);
            end
            2'd2: begin
                digit_c = disp.d2;
                blank_c = (disp.d3 == 4'd0) && (disp.d2 == 4'd0);
            end
            default: begin
                digit_c = disp.d3;
                blank_c = (disp.d3 == 4'd0);
            end
        endcase
        if (disp.dash)                  seg_c = SEG_DASH;
        else if (BLANK_LZ && blank_c)   seg_c = SEG_BLANK;
        else                            seg_c = seg_decode(digit_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre      <= '0;
            idx      <= '0;
            valid    <= 1'b0;
            last_val <= '0;
            disp     <= '0;
            fnd_com  <= 4'b1111;
            fnd_data <= 8'hFF;
        end else begin
            if (pre == PRE_MAX) begin
                pre <= '0;
                idx <= idx + 2'd1;
            end else begin
                pre <= pre + PRE_W'(1);
            end
            fnd_com  <= ~(4'b0001 << idx);
            fnd_data <= seg_c;
            if (start_c) last_val <= i_count;
            // Display updates atomically, only when a conversion completes
            if (done) begin
                valid <= 1'b1;
                disp  <= '{dash: (last_val > MAX_COUNT),
                           d3: bcd[15:12], d2: bcd[11:8], d1: bcd[7:4], d0: bcd[3:0]};
            end
        end
    end

endmodule

// File: tb/tb_fnd_controller.sv
// Bench for fnd_controller: two instances (with and without leading-zero
// blanking) checked every cycle against a timeline-based reference model.
module tb_fnd_controller;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] i_count;
    logic [3:0]  com0, com1;
    logic [7:0]  data0, data1;
    logic        busy0, busy1;

    always #5 clk = ~clk;

    fnd_controller #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_count(i_count),
        .fnd_com(com0), .fnd_data(data0), .o_busy(busy0)
    );

    fnd_controller #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .i_count(i_count),
        .fnd_com(com1), .fnd_data(data1), .o_busy(busy1)
    );

    int vectors     = 0;
    int miscompares = 0;
    int busy_cycles = 0;
    int seen6       = 0;

    // Reference model: conversion timer counts edges since capture
    int         m_pre, m_idx, m_timer, m_last, m_disp;
    bit         m_valid, m_dash, m_busy;
    logic [3:0] m_com;
    logic [7:0] m_data0, m_data1;
    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int         pow10 [4]   = '{1, 10, 100, 1000};

    function automatic logic [7:0] exp_seg(input int v, input bit dash, input int k, input bit blz);
        if (dash) return 8'hBF;
        if (blz && k > 0 && v < pow10[k]) return 8'hFF;
        return segtab[(v / pow10[k]) % 10];
    endfunction

    task automatic model_step(input bit r, input logic [13:0] c);
        if (r) begin
            m_pre = 0; m_idx = 0; m_timer = 0; m_valid = 1'b0; m_last = 0;
            m_disp = 0; m_dash = 1'b0; m_busy = 1'b0;
            m_com = 4'hF; m_data0 = 8'hFF; m_data1 = 8'hFF;
        end else begin
            m_com = 4'hF;
            m_com[m_idx] = 1'b0;
            m_data0 = exp_seg(m_disp, m_dash, m_idx, 1'b0);
            m_data1 = exp_seg(m_disp, m_dash, m_idx, 1'b1);
            if (m_pre == SCAN_DIV - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pre++;
            end
            if (m_timer == 0) begin
                if (!m_valid || int'(c) != m_last) begin
                    m_last  = int'(c);
                    m_timer = 1;
                end
            end else if (m_timer == 15) begin
                m_disp  = m_last;
                m_dash  = (m_last > 9999);
                m_valid = 1'b1;
                m_timer = 0;
            end else begin
                m_timer++;
            end
            m_busy = (m_timer != 0);
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input logic [13:0] c);
        rst     = r;
        i_count = c;
        @(posedge clk);
        model_step(r, c);
        #1;
        check("com0",  16'(com0),  16'(m_com));
        check("data0", 16'(data0), 16'(m_data0));
        check("busy0", 16'(busy0), 16'(m_busy));
        check("com1",  16'(com1),  16'(m_com));
        check("data1", 16'(data1), 16'(m_data1));
        check("busy1", 16'(busy1), 16'(m_busy));
        if (busy0 === 1'b1) busy_cycles++;
        if (data0 === 8'h82) seen6++;
    endtask

    task automatic run(input int n, input logic [13:0] c);
        for (int i = 0; i < n; i++) tick(1'b0, c);
    endtask

    initial begin
        logic [13:0] v;
        int          hold;

        // Reset and first conversion of 1234
        tick(1'b1, 14'd1234);
        tick(1'b1, 14'd1234);
        busy_cycles = 0;
        run(40, 14'd1234);
        check("busy_len", 16'(busy_cycles), 16'd15);

        // Value change latency
        run(40, 14'd9999);

        // Changes during a conversion: 6 must never reach the display
        run(30, 14'd4);
        seen6 = 0;
        run(3, 14'd5);
        run(5, 14'd6);
        run(50, 14'd7);
        check("never6", 16'(seen6), 16'd0);

        // Out of range then zero
        run(40, 14'd12000);
        run(40, 14'd0);

        // Leading-zero blanking (second instance)
        run(40, 14'd42);

        // Reset in the middle of a conversion
        run(8, 14'd1111);
        tick(1'b1, 14'd1111);
        check("rst_com",  16'(com0),  16'h000F);
        check("rst_data", 16'(data0), 16'h00FF);
        check("rst_busy", 16'(busy0), 16'h0000);
        run(40, 14'd1111);

        // Randomized values, hold times and occasional resets
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) v = 14'($urandom_range(10000, 16383));
            else                           v = 14'($urandom_range(0, 9999));
            hold = int'($urandom_range(1, 30));
            if ($urandom_range(0, 19) == 0) tick(1'b1, v);
            run(hold, v);
        end
        run(40, v);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fnd_controller.md
Name: fnd_controller

Overview:
- Downstream display stage for the 0–9999 up/down tick counter.
- Consumes the counter's 14-bit count value, converts it to four BCD digits with a sequential double-dabble converter, and time-multiplexes the digits onto a common-anode 4-digit 7-segment display (FND).
- Sits between the counter output and the board pins.

Parameters:
- SCAN_DIV, 100_000: clk cycles per digit slot. 1 kHz per digit at 100 MHz; benches override to a small value such as 4.
- BLANK_LZ, 0: when 1, leading zeros in thousands/hundreds/tens are blanked. The ones digit is never blanked.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_count  input  14  binary count from counter stage; legal range 0–9999.
- fnd_com  output  4  digit enables, active low; bit0 = ones … bit3 = thousands.
- fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active low.
- o_busy  output  1  high while the converter is in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state is registered.
- Reset values:
  - fnd_com = 4'b1111, fnd_data = 8'hFF, o_busy = 0.
  - Prescaler = 0, digit index = 0.
  - Display registers = 0.
  - valid flag = 0.
  - Converter FSM = IDLE.
- Scan prescaler: counts 0..SCAN_DIV-1 and wraps. On the wrap cycle, the 2-bit digit index increments, wrapping 3→0.
- Output register: every cycle after reset, the outputs load from the current index.
  - fnd_com = ~(4'b0001 << idx).
  - fnd_data = segment code of the display digit at idx.
  - Outputs therefore lag the index by one clock.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF, blank=FF. dp is always off (bit7 = 1).
- Converter FSM:
  - IDLE: if valid==0 or i_count != last_val, capture i_count into the shift register and last_val, clear the BCD accumulator and the 4-bit iteration count, then go to SHIFT.
  - SHIFT: 14 cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. After the 14th shift, go to DONE.
  - DONE: load the four display registers, set valid=1, then go to IDLE.
- Latency: a change presented while in IDLE reaches the display registers at the 16th rising edge after capture (1 capture + 14 shift + 1 load). It is visible on pins at the next output register update for that digit.
- Changes during SHIFT/DONE are ignored. When the FSM returns to IDLE, last_val mismatches, so the latest value is converted; intermediate values may be skipped.
- Display registers change only in DONE, so there is no partial/torn display mid-conversion.
- Out of range: if the captured value > 9999, DONE loads the dash flag and all four digits show dash (BF).
- BLANK_LZ=1: a digit shows blank (FF) if it and all more-significant digits are 0, except the ones digit.
  - Example: 42 → blank, blank, 4, 2.
  - Example: 0 → blank, blank, blank, 0.
- Reset mid-conversion: the FSM returns to IDLE and valid=0. The display returns to 0s, and a fresh conversion starts on the first cycle after rst deasserts.
- Constant input: after the first conversion, no further conversions occur (o_busy stays 0).

Decomposition:
- Shared package fnd_pkg:
  - segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - MAX_COUNT = 9999;
  - converter state encoding (IDLE, SHIFT, DONE).
- Sub-module bin2bcd_seq (the FSM plus shift register). Ports: clk, rst, i_bin[13:0], i_start, o_bcd[15:0], o_done, o_busy.
- Top level holds the change detect, prescaler, digit index, digit mux, blanking and the segment decoder.

Test Plan:
- Reset/first conversion (SCAN_DIV=4):
  - Stimulus: i_count=1234, rst 1 for 2 clks then 0.
  - Required: o_busy high for 15 clks; then over one scan frame the pins cycle through com 1110/data 99 ('4'), 1101/B0 ('3'), 1011/A4 ('2'), 0111/F9 ('1').
- Value change latency:
  - Stimulus: after idle, i_count 1234→9999.
  - Required: display registers hold 1,2,3,4 until exactly 16 clks after capture, then all digits show 90.
- Change during conversion:
  - Stimulus: i_count 5→6 at SHIFT cycle 3, then 6→7 at cycle 8.
  - Required: display shows 0005, then one further conversion yields 0007; 0006 is never displayed.
- Out of range:
  - Stimulus: i_count=14'd12000.
  - Required: all four digits show BF.
  - Then i_count=0 → digits show C0,C0,C0,C0.
- Leading-zero blank (BLANK_LZ=1):
  - i_count=42 → thousands/hundreds FF, tens 99, ones A4.
  - i_count=0 → FF,FF,FF,C0.
- Reset mid-operation:
  - Stimulus: assert rst at SHIFT cycle 7.
  - Required: next clk fnd_com=1111, fnd_data=FF, o_busy=0.
  - After release, the conversion restarts and shows the current i_count within 16 clks plus one scan frame.
